// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a transmit FIFO
// on the core's unified memory port.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Sel,
   output logic        tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW:0] wp, rp, count;
   logic [31:0] count32;
   logic [3:0] cnt_sat;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] bit_idx, bit_n;
   logic [7:0] sh, sh_n;
   logic [1:0] off;
   logic tx_n, pop, launch, tick0, en, ovf, full, empty, busy;
   logic wr, push, flush, clr_ovf, unused_ok;
   assign Sel = Adr[31:4] == BASE_ADDR[31:4];
   assign off = Adr[3:2];
   assign wr = Sel && MemWrite;
   assign push = wr && off == 2'd0;
   assign flush = wr && off == 2'd2 && WriteData[1];
   assign clr_ovf = wr && off == 2'd2 && WriteData[2];
   assign count = wp - rp;
   assign count32 = 32'(count);
   assign cnt_sat = count32 > 32'd15 ? 4'hF : count32[3:0];
   assign empty = wp == rp;
   assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
   assign busy = state != IDLE;
   assign unused_ok = ^{WriteData[31:8], Adr[1:0]};
   assign ReadData = !Sel ? 32'd0 :
                     off == 2'd1 ? {24'd0, cnt_sat, ovf, busy, empty, full} :
                     off == 2'd2 ? {31'd0, en} : 32'd0;
   // full is judged before the edge, so a push while full drops even if a pop coincides
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wp <= '0;
         rp <= '0;
         ovf <= 1'b0;
         en <= 1'b1;
      end else begin
         if (push && full) ovf <= 1'b1;
         else if (clr_ovf) ovf <= 1'b0;
         if (wr && off == 2'd2) en <= WriteData[0];
         if (push && !full) wp <= wp + 1'b1;
         if (flush) rp <= wp;
         else if (pop) rp <= rp + 1'b1;
      end
   always_ff @(posedge clk)
      if (push && !full) mem[wp[AW-1:0]] <= WriteData[7:0];
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      bit_n = bit_idx;
      sh_n = sh;
      tx_n = tx;
      pop = 1'b0;
      tick0 = cnt == '0;
      launch = en && !empty && (state == IDLE || (state == STOP && tick0));
      case (state)
         IDLE: ;
         START:
            if (tick0) begin
               state_n = DATA;
               cnt_n = RELOAD;
               bit_n = 3'd0;
               tx_n = sh[0];
            end else cnt_n = cnt - 1'b1;
         DATA:
            if (tick0) begin
               cnt_n = RELOAD;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n = 1'b1;
               end else begin
                  bit_n = bit_idx + 3'd1;
                  sh_n = sh >> 1;
                  tx_n = sh[1];
               end
            end else cnt_n = cnt - 1'b1;
         STOP:
            if (tick0) state_n = IDLE;
            else cnt_n = cnt - 1'b1;
      endcase
      // a launch from STOP chains frames with no idle gap
      if (launch) begin
         state_n = START;
         pop = 1'b1;
         sh_n = mem[rp[AW-1:0]];
         cnt_n = RELOAD;
         bit_n = 3'd0;
         tx_n = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         sh <= '0;
         tx <= 1'b1;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bit_idx <= bit_n;
         sh <= sh_n;
         tx <= tx_n;
      end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the processor's unified memory port. It sits directly downstream of the multicycle core and decodes `Adr`, `MemWrite` and `WriteData` for a 16-byte register window. Stores to the window push bytes into a transmit FIFO. A serialiser drains the FIFO as 8N1 frames on `tx`. Loads from the window return status and control on `ReadData`; the system read mux selects this data when `Sel` is high.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: window base address; bits [3:0] must be 0.
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; minimum 2.
- `FIFO_DEPTH`, default 8: transmit FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `MemWrite`  input  1: store strobe from the core.
- `Adr`  input  32: byte address from the core.
- `WriteData`  input  32: store data from the core.
- `ReadData`  output  32: combinational load data for the window; 0 when `Sel` is low.
- `Sel`  output  1: combinational; high when `Adr[31:4] == BASE_ADDR[31:4]`.
- `tx`  output  1: registered serial output; idle level is high.

## Operation
- Register offset is `Adr[3:2]`. `Adr[1:0]` is ignored. A write occurs when `Sel && MemWrite` at a clock edge.
- Offset 0, TXDATA:
  - Write pushes `WriteData[7:0]` into the FIFO.
  - Read returns 0.
- Offset 1, STATUS (read-only):
  - bit0 = full; bit1 = empty; bit2 = busy (serialiser not IDLE); bit3 = overflow (sticky).
  - bits[7:4] = FIFO count, saturating at 15.
  - All other bits are 0.
- Offset 2, CTRL:
  - bit0 = enable, read/write.
  - Writing 1 to bit1 flushes the FIFO; bit1 reads as 0.
  - Writing 1 to bit2 clears overflow; bit2 reads as 0.
- Offset 3 is reserved: reads return 0 and writes are ignored.
- Push while full (full evaluated before the edge): the byte is dropped and overflow is set. This holds even if a pop happens on the same edge.
- Flush and push in the same CTRL/TXDATA sequence cannot coincide, because each is a single write. Flush on the same edge as a serialiser pop: flush wins, and the popped byte is still transmitted.
- Serialiser FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when enable is set and the FIFO is not empty. The FIFO head is popped into the shift register on that edge, and `tx` goes to 0.
  - START, after CLKS_PER_BIT cycles → DATA. `tx` = bit 0.
  - DATA shifts LSB-first. Each bit lasts CLKS_PER_BIT cycles. After bit 7 → STOP with `tx` = 1.
  - STOP, after CLKS_PER_BIT cycles:
    - → START, popping the next byte, if enable is set and the FIFO is not empty (back-to-back frames with no idle gap).
    - Otherwise → IDLE.
- Clearing enable mid-frame: the current frame completes, and no further pop occurs.
- Flush mid-frame: the in-flight frame completes.
- The baud counter is a down-counter of width clog2(CLKS_PER_BIT). It reloads CLKS_PER_BIT-1 at every bit boundary.

## Timing
- Reset values (asynchronous, while `reset` is 0):
  - `tx` = 1; FSM = IDLE; FIFO empty with pointers 0; overflow = 0; enable = 1; baud counter = 0.
  - STATUS reads as 32'h0000_0002.
- `ReadData` and `Sel` are purely combinational from `Adr` and the register state. No read latency: the core samples them in the same cycle.
- Write at edge N: FIFO count and flags update at edge N.
- Serialiser latency: if the FIFO was empty, the FSM is IDLE and enable is set, a push at edge N causes the pop and the `tx` falling edge at edge N+1.
- One frame = 10·CLKS_PER_BIT cycles, from the `tx` start-bit edge to the first cycle after the stop bit.
- busy is 1 from the START entry edge until the edge that returns the FSM to IDLE.
- FIFO pointers have width clog2(FIFO_DEPTH)+1 and wrap modulo 2·FIFO_DEPTH. Full means the pointers differ only in the MSB.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronously) and all state is discarded.

## Test plan
- Reset then read: hold `reset`=0, then release. Read BASE+4 → 32'h2; read BASE+8 → 32'h1; `tx`=1; read BASE+C → 0.
- Single byte, CLKS_PER_BIT=4: store 8'hA5 at edge N.
  - `tx` low from N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1, then 4 cycles high.
  - busy drops at N+41.
- Back-to-back: push 8'h55 and 8'h0F on consecutive cycles. The second start bit begins immediately after the first stop bit, with no idle cycle. Count reads 1 during frame 1.
- Overflow, FIFO_DEPTH=8, enable=0:
  - Push 9 bytes. STATUS = full, count 8, overflow=1; the 9th byte is absent from the output after enabling.
  - Write CTRL=32'h5. Overflow reads 0 and transmission starts.
- Flush mid-frame: push 3 bytes and wait for the first start bit, then write CTRL=32'h3. The first frame completes, then the FSM goes IDLE. STATUS reads empty=1 and count 0.
- Decode and reset: access `BASE_ADDR`+16 → `Sel`=0 and `ReadData`=0, with no FIFO change. Drive `reset` low mid-frame → `tx`=1 in the same cycle, and STATUS = 32'h2 after release.
